uart_program_loader: RTL and testbench

Boot-time loader that sits upstream of the pipeline's instruction memory. It receives a program over the board `rx` line (8N1 UART), assembles little-endian 32-bit instruction words, and writes them sequentially into instruction memory starting at word 0. While loading, it holds the pipeline in reset; once the declared word count has been written, it releases the pipeline.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 91 +++++++++
 rtl/uart_program_loader.sv | 116 +++++++++++
 tb/tb_uart_program_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and protocol constants for the UART program loader.
package loader_pkg;

  localparam int WORD_W         = 32;
  localparam int COUNT_BYTES    = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    L_CNT0,
    L_CNT1,
    L_DATA,
    L_DONE,
    L_ERR
  } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) begin
              byte_data  <= shreg;
              byte_valid <= 1'b1;
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: UART byte stream -> sequential instruction-memory writes,
// holding the pipeline in reset until the declared word count is loaded.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              frame_err
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  ld_state_t   state;
  logic [7:0]  cnt_lo;
  logic [15:0] decl;
  logic [15:0] lim;
  logic [15:0] words;
  logic [1:0]  bidx;
  logic        word_done;
  logic [15:0] decl_nxt;

  assign decl_nxt = {byte_data, cnt_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= L_CNT0;
      cnt_lo    <= '0;
      decl      <= '0;
      lim       <= '0;
      words     <= '0;
      bidx      <= '0;
      word_done <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      word_done <= 1'b0;
      if (byte_err && state != L_DONE) begin
        state     <= L_ERR;
        frame_err <= 1'b1;
      end else begin
        unique case (state)
          L_CNT0: begin
            if (byte_valid) begin
              cnt_lo <= byte_data;
              state  <= L_CNT1;
            end
          end
          L_CNT1: begin
            if (byte_valid) begin
              decl <= decl_nxt;
              lim  <= (32'(decl_nxt) > 32'(MAX_WORDS)) ?
                      16'(MAX_WORDS) : decl_nxt;
              if (decl_nxt == '0) begin
                state     <= L_DONE;
                cpu_reset <= 1'b0;
                load_done <= 1'b1;
              end else begin
                state <= L_DATA;
              end
            end
          end
          L_DATA: begin
            if (byte_valid) begin
              mem_wdata[8*bidx +: 8] <= byte_data;
              bidx <= bidx + 1'b1;
              if (bidx == 2'(BYTES_PER_WORD - 1)) begin
                word_done <= 1'b1;
                mem_we    <= (words < lim);
              end
            end
            // Words past a clamped count still advance the count, unwritten.
            if (word_done) begin
              words <= words + 16'd1;
              if (mem_we) mem_addr <= mem_addr + 32'd1;
              if (16'(words + 16'd1) == decl) begin
                state     <= L_DONE;
                cpu_reset <= 1'b0;
                load_done <= 1'b1;
              end
            end
          end
          L_DONE, L_ERR: ;
          default: state <= L_CNT0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized bench: two loaders (deep and MAX_WORDS=2) share one rx line.
module tb_uart_program_loader;
  import loader_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        we0, we1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic        cr0, cr1, ld0, ld1, fe0, fe1;

  uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .cpu_reset(cr0), .load_done(ld0), .frame_err(fe0)
  );

  uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(2)) dut_c (
    .clk(clk), .reset(reset), .rx(rx),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .cpu_reset(cr1), .load_done(ld1), .frame_err(fe1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge
  logic [63:0] wq0[$];
  logic [63:0] wq1[$];
  int   cyc = 0;
  int   consec[2];
  int   last_we[2];
  int   done_at[2];
  logic pwe[2];
  logic pld[2];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      wq0.delete();
      wq1.delete();
      consec  = '{0, 0};
      last_we = '{-1, -1};
      done_at = '{-1, -1};
      pwe     = '{1'b0, 1'b0};
      pld     = '{1'b0, 1'b0};
    end else begin
      if (we0) begin
        wq0.push_back({addr0, wd0});
        if (pwe[0]) consec[0]++;
        last_we[0] = cyc;
      end
      if (we1) begin
        wq1.push_back({addr1, wd1});
        if (pwe[1]) consec[1]++;
        last_we[1] = cyc;
      end
      if (ld0 && !pld[0]) done_at[0] = cyc;
      if (ld1 && !pld[1]) done_at[1] = cyc;
      pwe[0] = we0;
      pwe[1] = we1;
      pld[0] = ld0;
      pld[1] = ld1;
    end
  end

  // Stimulus record: bytes with good stop bits, and where the first bad one fell
  logic [7:0]  sq[$];
  int          bad_at = -1;
  logic [31:0] wv[$];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sq.delete();
    bad_at = -1;
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit good, input int gap);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(good);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    if (good) sq.push_back(b);
    else if (bad_at < 0) bad_at = sq.size();
  endtask

  task automatic send_stream(input int count, input int maxgap);
    logic [15:0] c;
    logic [31:0] w;
    c = 16'(count);
    send(c[7:0], 1'b1, $urandom_range(0, maxgap));
    send(c[15:8], 1'b1, $urandom_range(0, maxgap));
    foreach (wv[i]) begin
      w = wv[i];
      for (int k = 0; k < 4; k++)
        send(w[8*k +: 8], 1'b1, $urandom_range(0, maxgap));
    end
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
  endtask

  // Reference: expected writes/flags derived from the byte stream alone
  task automatic verify(input int d, input int max, input string sc);
    logic [63:0] q[$];
    logic [31:0] ew;
    int n, decl, exp_nw, b;
    bit done, err;
    string p;
    p = {sc, d ? ".clamp" : ".main"};
    if (d == 0) q = wq0;
    else q = wq1;
    n = (bad_at >= 0) ? bad_at : sq.size();
    decl = (n >= COUNT_BYTES) ? int'({sq[1], sq[0]}) : -1;
    done = (decl >= 0) && (n >= COUNT_BYTES + BYTES_PER_WORD * decl);
    err = (bad_at >= 0) && !done;
    exp_nw = 0;
    for (int w = 0; w < decl && w < max; w++)
      if (COUNT_BYTES + BYTES_PER_WORD * (w + 1) <= n) exp_nw++;
    chk({p, ".nwrites"}, q.size(), exp_nw);
    for (int w = 0; w < exp_nw && w < q.size(); w++) begin
      b = COUNT_BYTES + BYTES_PER_WORD * w;
      ew = {sq[b+3], sq[b+2], sq[b+1], sq[b]};
      chk($sformatf("%s.addr%0d", p, w), q[w][63:32], w);
      chk($sformatf("%s.data%0d", p, w), q[w][31:0], ew);
    end
    chk({p, ".load_done"}, d ? ld1 : ld0, done);
    chk({p, ".cpu_reset"}, d ? cr1 : cr0, !done);
    chk({p, ".frame_err"}, d ? fe1 : fe0, err);
    chk({p, ".consec_we"}, consec[d], 0);
    if (done && exp_nw > 0 && decl <= max)
      chk({p, ".release_lat"}, done_at[d] - last_we[d], 1);
  endtask

  task automatic chk_reset_vals(input string sc);
    chk({sc, ".rst_we"}, we0, 0);
    chk({sc, ".rst_addr"}, addr0, 0);
    chk({sc, ".rst_wdata"}, wd0, 0);
    chk({sc, ".rst_cpu_reset"}, cr0, 1);
    chk({sc, ".rst_load_done"}, ld0, 0);
    chk({sc, ".rst_frame_err"}, fe0, 0);
    chk({sc, ".rst_addr_c"}, addr1, 0);
    chk({sc, ".rst_cpu_reset_c"}, cr1, 1);
  endtask

  initial begin
    int cnt, nw;

    do_reset();
    chk_reset_vals("init");

    // Normal load, back-to-back bytes
    wv = '{32'h2008_0005, 32'h8C09_0004};
    send_stream(2, 0);
    settle();
    verify(0, 1024, "normal");
    verify(1, 2, "normal");
    // A framing error after release is ignored
    send(8'h55, 1'b0, 200);
    verify(0, 1024, "err_after_done");

    // Zero count
    do_reset();
    wv.delete();
    send_stream(0, 3);
    settle();
    verify(0, 1024, "zero");
    verify(1, 2, "zero");

    // Framing error on the third byte
    do_reset();
    send(8'h02, 1'b1, 0);
    send(8'h00, 1'b1, 0);
    send(8'hA5, 1'b0, 200);
    for (int i = 0; i < 8; i++) send(8'($urandom), 1'b1, 0);
    settle();
    verify(0, 1024, "frame");
    verify(1, 2, "frame");

    // Glitch rejection, then a normal load
    do_reset();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    wv = '{32'($urandom)};
    send_stream(1, 2);
    settle();
    verify(0, 1024, "glitch");
    verify(1, 2, "glitch");

    // Reset after 5 of 8 data bytes, then full resend
    do_reset();
    send(8'h02, 1'b1, 0);
    send(8'h00, 1'b1, 0);
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b1, 0);
    settle();
    verify(0, 1024, "partial");
    do_reset();
    chk_reset_vals("midreset");
    wv = '{32'hDEAD_BEEF};
    send_stream(1, 0);
    settle();
    verify(0, 1024, "reload");
    verify(1, 2, "reload");

    // Declared count beyond the shallow loader's depth
    do_reset();
    wv = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    send_stream(3, 0);
    settle();
    verify(0, 1024, "clamp");
    verify(1, 2, "clamp");

    // Random loads
    for (int it = 0; it < 6; it++) begin
      do_reset();
      cnt = $urandom_range(0, 4);
      wv.delete();
      for (int w = 0; w < cnt; w++) wv.push_back($urandom);
      send_stream(cnt, 12);
      settle();
      verify(0, 1024, $sformatf("rand%0d", it));
      verify(1, 2, $sformatf("rand%0d", it));
    end

    // Random load cut short by a framing error mid-stream
    do_reset();
    cnt = $urandom_range(2, 4);
    nw = $urandom_range(1, cnt - 1);
    send(8'(cnt), 1'b1, 0);
    send(8'h00, 1'b1, 0);
    for (int i = 0; i < 4 * nw; i++) send(8'($urandom), 1'b1, 1);
    send(8'h3C, 1'b0, 200);
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1, 0);
    settle();
    verify(0, 1024, "rand_err");
    verify(1, 2, "rand_err");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
